// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: datapath widths, the alu_control encodings and the
// highest legal control code.
package alu_defs;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_SLL  = 5'd0,
        ALU_SRL  = 5'd1,
        ALU_SRA  = 5'd2,
        ALU_SLLV = 5'd3,
        ALU_SRLV = 5'd4,
        ALU_SRAV = 5'd5,
        ALU_ADD  = 5'd6,
        ALU_ADDU = 5'd7,
        ALU_SUB  = 5'd8,
        ALU_SUBU = 5'd9,
        ALU_AND  = 5'd10,
        ALU_OR   = 5'd11,
        ALU_XOR  = 5'd12,
        ALU_NOR  = 5'd13,
        ALU_SLT  = 5'd14,
        ALU_SLTU = 5'd15,
        ALU_LUI  = 5'd16
    } alu_ctrl_e;

    localparam logic [CTRL_W-1:0] ALU_CTRL_MAX = 5'b10000;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; unknown control codes return zero with no overflow.
module alu
    import alu_defs::*;
(
    input  logic [CTRL_W-1:0]  alu_control,
    input  logic [DATA_W-1:0]  rs,
    input  logic [DATA_W-1:0]  rt,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result,
    output logic               overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = rs + rt;
    assign diff = rs - rt;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            ALU_SLL:  result = rt << shamt;
            ALU_SRL:  result = rt >> shamt;
            ALU_SRA:  result = $unsigned($signed(rt) >>> shamt);
            ALU_SLLV: result = rt << rs[SHAMT_W-1:0];
            ALU_SRLV: result = rt >> rs[SHAMT_W-1:0];
            ALU_SRAV: result = $unsigned($signed(rt) >>> rs[SHAMT_W-1:0]);
            ALU_ADD: begin
                result   = sum;
                overflow = (rs[DATA_W-1] == rt[DATA_W-1]) && (sum[DATA_W-1] != rs[DATA_W-1]);
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result   = diff;
                overflow = (rs[DATA_W-1] != rt[DATA_W-1]) && (diff[DATA_W-1] != rs[DATA_W-1]);
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = rs & rt;
            ALU_OR:   result = rs | rt;
            ALU_XOR:  result = rs ^ rt;
            ALU_NOR:  result = ~(rs | rt);
            ALU_SLT:  result = DATA_W'($signed(rs) < $signed(rt));
            ALU_SLTU: result = DATA_W'(rs < rt);
            ALU_LUI:  result = {rt[15:0], 16'h0000};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after ptr, wrapping modulo NREQ; no grant when en is low.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]                         req,
    input  logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] ptr,
    input  logic                                    en,
    output logic [NREQ-1:0]                         grant
);

    localparam int unsigned IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between NREQ requesters, with a one-entry
// registered response and a saturating overflow counter.
module alu_share_arb
    import alu_defs::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1,
    parameter int unsigned OVFW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [CTRL_W*NREQ-1:0]  req_ctrl,
    input  logic [DATA_W*NREQ-1:0]  req_rs,
    input  logic [DATA_W*NREQ-1:0]  req_rt,
    input  logic [SHAMT_W*NREQ-1:0] req_shamt,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_ovf,
    output logic                    resp_illegal,
    output logic [OVFW-1:0]         ovf_count,
    input  logic                    ovf_clr
);

    logic [IDW-1:0]     rr_ptr;
    logic               can_issue;
    logic [NREQ-1:0]    grant;
    logic               any_gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     ptr_nxt;

    logic [CTRL_W-1:0]  ctrl_lane  [NREQ];
    logic [DATA_W-1:0]  rs_lane    [NREQ];
    logic [DATA_W-1:0]  rt_lane    [NREQ];
    logic [SHAMT_W-1:0] shamt_lane [NREQ];

    logic [CTRL_W-1:0]  ctrl_sel;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_ovf;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign ctrl_lane[g]  = req_ctrl[CTRL_W*g +: CTRL_W];
        assign rs_lane[g]    = req_rs[DATA_W*g +: DATA_W];
        assign rt_lane[g]    = req_rt[DATA_W*g +: DATA_W];
        assign shamt_lane[g] = req_shamt[SHAMT_W*g +: SHAMT_W];
    end

    // A drained result frees the register in the same cycle, so a new grant can follow.
    assign can_issue = !resp_valid || resp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (can_issue),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_gnt   = |grant;

    always_comb begin
        gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gnt_idx = IDW'(k);
            end
        end
    end

    assign sel      = any_gnt ? gnt_idx : rr_ptr;
    assign ptr_nxt  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign ctrl_sel = ctrl_lane[sel];

    alu u_alu (
        .alu_control (ctrl_sel),
        .rs          (rs_lane[sel]),
        .rt          (rt_lane[sel]),
        .shamt       (shamt_lane[sel]),
        .result      (alu_result),
        .overflow    (alu_ovf)
    );

    // Response register, arbitration pointer and overflow counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_data    <= '0;
            resp_ovf     <= 1'b0;
            resp_illegal <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr       <= ptr_nxt;
                resp_valid   <= 1'b1;
                resp_id      <= gnt_idx;
                resp_data    <= alu_result;
                resp_ovf     <= alu_ovf;
                resp_illegal <= (ctrl_sel > ALU_CTRL_MAX);
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end

            if (ovf_clr) begin
                ovf_count <= '0;
            end else if (any_gnt && alu_ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + OVFW'(1);
            end
        end
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one instance of the team's 32-bit combinational ALU (module `alu`) between NREQ requesters, e.g. the integer execute stage and the address/branch-compare path.
- Arbitrates round-robin and drives the shared ALU with the winner's operands.
- Captures the result, overflow and an illegal-opcode flag in a one-entry output register, returned with a requester ID over a valid/ready handshake.
- Keeps a saturating count of add/sub overflows for the exception/status logic.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of the requester ID; must equal max(1, ceil(log2(NREQ))).
- OVFW, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_ctrl  in  5*NREQ  alu_control code; requester i is in bits [5i+4:5i].
- req_rs  in  32*NREQ  rs operand, packed the same way.
- req_rt  in  32*NREQ  rt operand.
- req_shamt  in  5*NREQ  shift amount.
- resp_valid  out  1  output register holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that produced the result.
- resp_data  out  32  ALU result.
- resp_ovf  out  1  signed overflow (add/sub codes only, as flagged by the ALU).
- resp_illegal  out  1  alu_control code was greater than 5'b10000.
- ovf_count  out  OVFW  saturating count of overflowing results.
- ovf_clr  in  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0, resp_illegal=0;
  - ovf_count=0 and the round-robin pointer rr_ptr=0.
  - Reset mid-operation discards any held result; no partial state survives.
- req_ready is combinational and depends only on req_valid, rr_ptr, resp_valid and resp_ready.
  - A request is transferred when req_valid[i] and req_ready[i] are both 1 in the same cycle.
- can_issue = !resp_valid || resp_ready.
  - This allows a new grant in the same cycle the held result drains, giving 1 result per cycle.
- Grant rule: when can_issue, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - At most one req_ready bit is high. If can_issue=0, all req_ready bits are 0.
- After a grant to requester i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr is unchanged.
- Shared ALU inputs are muxed from the granted lane.
  - With no grant, the mux selects lane rr_ptr; the ALU output is then ignored.
- Latency: request accepted in cycle N. At edge N+1:
  - resp_valid=1;
  - resp_data, resp_ovf and resp_id are registered;
  - resp_illegal = (ctrl > 5'b10000).
- Output register update rules:
  - If resp_valid && resp_ready and there is no new grant, resp_valid <= 0; the data fields hold their last values.
  - If resp_valid && !resp_ready, all resp_* outputs are held stable (required by the handshake).
- Requesters must hold their operands stable while req_valid=1 && !req_ready. The block does not check this.
- Illegal control code: the request is still accepted; resp_data=0 (ALU default), resp_ovf=0, resp_illegal=1.
- ovf_count increments by 1 on each accepted grant whose ALU overflow output is 1, saturating at all-ones.
  - If ovf_clr is 1 in the same cycle, ovf_clr wins and the count becomes 0.

Decomposition:
- Shared package/include file `alu_defs`: the 17 alu_control codes (sll through lui) and the constant ALU_CTRL_MAX = 5'b10000.
- The existing `alu` is instantiated unchanged; its overflow output feeds resp_ovf and the counter.
- One natural sub-module: `rr_arbiter` (parameter NREQ).
  - Inputs: req, ptr, en. Output: one-hot grant.
  - Pure combinational; rr_ptr stays in the parent.

Test Plan:
- Single requester, no stall:
  - Stimulus: lane0 presents add, rs=5, rt=7 at cycle 1.
  - Required: req_ready[0]=1 in cycle 1; cycle 2 gives resp_valid=1, data=12, id=0, ovf=0.
- Fairness:
  - Stimulus: both lanes valid continuously; lane0 sub 10-3, lane1 or 0xF0|0x0F; resp_ready=1.
  - Required: grants alternate 0,1,0,1; results alternate 7, 0xFF with matching ids; one result per cycle.
- Backpressure:
  - Stimulus: resp_ready=0 for 3 cycles with a result held; lane1 is valid.
  - Required: req_ready=0 for those cycles; resp_* stable.
  - Then resp_ready=1: lane1 is granted in that same cycle and its result appears the next cycle.
- Overflow and counter:
  - Stimulus: add 0x7FFFFFFF+1, then sub 0x80000000-1.
  - Required: both give resp_ovf=1 and ovf_count goes 0→1→2.
  - Then preload with 255 overflows: count stays at 255. Then ovf_clr together with an overflowing grant: count=0.
- Illegal opcode:
  - Stimulus: ctrl=5'b10101, rs=3, rt=4.
  - Required: accepted; resp_data=0, resp_illegal=1, resp_ovf=0, ovf_count unchanged.
- Reset mid-operation:
  - Stimulus: rst_n=0 while resp_valid=1 and lane1 is valid.
  - Required: the next cycle has resp_valid=0, ovf_count=0, rr_ptr=0.
  - After release, lane0 wins first if both lanes are valid.
